// File: rtl/fifo_fwft_ctrl.sv
// First-word-fall-through FIFO controller driving an external simple dual-port RAM.
// Define FIFO_BYPASS_EN for same-cycle write/read to an empty RAM region (needs RAM ENABLE_BYPASS=1).
module fifo_fwft_ctrl #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_en,
  output logic                   full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   empty,
  output logic [DEPTH_WIDTH:0]   count,
  output logic [DEPTH_WIDTH-1:0] ram_waddr,
  output logic                   ram_we,
  output logic [DATA_WIDTH-1:0]  ram_din,
  output logic [DEPTH_WIDTH-1:0] ram_raddr,
  output logic                   ram_re,
  input  logic [DATA_WIDTH-1:0]  ram_dout
);

  localparam logic [DEPTH_WIDTH:0] CAPACITY = (DEPTH_WIDTH + 1)'(1) << DEPTH_WIDTH;

  logic [DEPTH_WIDTH:0] wptr;
  logic [DEPTH_WIDTH:0] rptr;
  logic                 valid;
  logic                 push;
  logic                 pop;
  logic                 ram_avail;

  always_comb begin
    push = wr_en && !full;
    pop  = rd_en && valid;
`ifdef FIFO_BYPASS_EN
    // RAM forwards the same-cycle write, so an empty region can be read as it is filled.
    ram_avail = (rptr != wptr) || (push && (rptr == wptr) && (!valid || pop));
`else
    ram_avail = (rptr != wptr);
`endif
    ram_we    = !rst && push;
    ram_re    = !rst && ram_avail && (!valid || pop);
    ram_waddr = wptr[DEPTH_WIDTH-1:0];
    ram_din   = wr_data;
    ram_raddr = rptr[DEPTH_WIDTH-1:0];
  end

  assign rd_data = ram_dout;
  assign empty   = !valid;
  assign full    = (count == CAPACITY);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= 1'b0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (ram_re)
        rptr <= rptr + 1'b1;
      if (ram_re)
        valid <= 1'b1;
      else if (pop)
        valid <= 1'b0;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

endmodule
